// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - snake game-state FSM, move-tick generator and filtered turn queue
module snake_dir_ctrl #(
    parameter int          TICK_DIV    = 12_500_000,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [1:0]  INIT_DIR    = 2'b11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] dir_in,
    input  logic       dir_valid_in,
    input  logic       start_pause_in,
    input  logic       reset_event_in,
    input  logic       game_over_in,
    output logic       move_tick_out,
    output logic [1:0] cur_dir_out,
    output logic [1:0] game_state_out,
    output logic [2:0] queue_count_out
);

    localparam int             CW       = $clog2(TICK_DIV);
    localparam int             PW       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(QUEUE_DEPTH - 1);
    localparam logic [2:0]     Q_FULL   = 3'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [1:0]    q [QUEUE_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [2:0]    count;
    logic [1:0]    cur_dir;
    logic          move_tick;

    logic          clear;
    logic          wrap;
    logic          pop;
    logic          push;
    logic [PW-1:0] newest_ptr;
    logic [1:0]    ref_dir;

    function automatic logic opposite(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b01;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Turn reference is the newest queued entry, sampled before any same-cycle pop.
    always_comb begin
        clear      = reset_event_in || (state == ST_OVER && start_pause_in);
        wrap       = (state == ST_RUN) && (cnt == CNT_LAST) && !game_over_in;
        pop        = wrap && (count != 3'd0);
        newest_ptr = (wr_ptr == '0) ? PTR_LAST : wr_ptr - 1'b1;
        ref_dir    = (count != 3'd0) ? q[newest_ptr] : cur_dir;
        push       = (state == ST_RUN) && dir_valid_in
                     && (dir_in != ref_dir) && !opposite(dir_in, ref_dir)
                     && ((count != Q_FULL) || pop);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= 3'd0;
            cur_dir   <= INIT_DIR;
            move_tick <= 1'b0;
        end else begin
            move_tick <= wrap;
            if (push) begin
                q[wr_ptr] <= dir_in;
                wr_ptr    <= next_ptr(wr_ptr);
            end
            if (pop) begin
                cur_dir <= q[rd_ptr];
                rd_ptr  <= next_ptr(rd_ptr);
            end
            count <= count + {2'b00, push} - {2'b00, pop};

            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (dir_valid_in && !opposite(dir_in, cur_dir))
                        cur_dir <= dir_in;
                    if (start_pause_in)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (game_over_in) begin
                        state <= ST_OVER;
                        cnt   <= '0;
                    end else begin
                        cnt <= wrap ? '0 : cnt + 1'b1;
                        if (start_pause_in)
                            state <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (start_pause_in)
                        state <= ST_RUN;
                end
                ST_OVER: begin
                    cnt <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign move_tick_out   = move_tick;
    assign cur_dir_out     = cur_dir;
    assign game_state_out  = state;
    assign queue_count_out = count;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// tb/tb_snake_dir_ctrl.sv - directed scoreboard bench for snake_dir_ctrl
module tb_snake_dir_ctrl;

    localparam int TD = 4;
    localparam int QD = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dir_in;
    logic       dir_valid_in;
    logic       start_pause_in;
    logic       reset_event_in;
    logic       game_over_in;
    logic       move_tick_out;
    logic [1:0] cur_dir_out;
    logic [1:0] game_state_out;
    logic [2:0] queue_count_out;

    snake_dir_ctrl #(.TICK_DIV(TD), .QUEUE_DEPTH(QD), .INIT_DIR(2'b11)) dut (
        .clk             (clk),
        .reset           (reset),
        .dir_in          (dir_in),
        .dir_valid_in    (dir_valid_in),
        .start_pause_in  (start_pause_in),
        .reset_event_in  (reset_event_in),
        .game_over_in    (game_over_in),
        .move_tick_out   (move_tick_out),
        .cur_dir_out     (cur_dir_out),
        .game_state_out  (game_state_out),
        .queue_count_out (queue_count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       tick;
        logic [1:0] dir;
        logic [1:0] st;
        logic [2:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue the outputs expected after the next edge, clock once, then score them.
    task automatic step(input string tag, input logic tick, input logic [1:0] dir,
                        input logic [1:0] st, input logic [2:0] cnt);
        exp_t e;
        e.tag = tag; e.tick = tick; e.dir = dir; e.st = st; e.cnt = cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        dir_valid_in   = 1'b0;
        start_pause_in = 1'b0;
        reset_event_in = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".tick"},  {3'b0, move_tick_out},  {3'b0, e.tick});
            chk({e.tag, ".dir"},   {2'b0, cur_dir_out},    {2'b0, e.dir});
            chk({e.tag, ".state"}, {2'b0, game_state_out}, {2'b0, e.st});
            chk({e.tag, ".count"}, {1'b0, queue_count_out}, {1'b0, e.cnt});
        end
    endtask

    task automatic dir_pulse(input logic [1:0] d);
        dir_in       = d;
        dir_valid_in = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        dir_in         = 2'b00;
        dir_valid_in   = 1'b0;
        start_pause_in = 1'b0;
        reset_event_in = 1'b0;
        game_over_in   = 1'b0;

        for (int i = 0; i < 3; i++) begin
            dir_in         = 2'($urandom_range(0, 3));
            dir_valid_in   = 1'($urandom_range(0, 1));
            start_pause_in = 1'($urandom_range(0, 1));
            reset_event_in = 1'($urandom_range(0, 1));
            game_over_in   = 1'($urandom_range(0, 1));
            step($sformatf("reset%0d", i), 1'b0, 2'b11, 2'b00, 3'd0);
        end
        reset        = 1'b0;
        game_over_in = 1'b0;

        // IDLE: direct writes, reversal dropped
        dir_pulse(2'b10); step("idle_rev",  1'b0, 2'b11, 2'b00, 3'd0);
        dir_pulse(2'b00); step("idle_up",   1'b0, 2'b00, 2'b00, 3'd0);
        dir_pulse(2'b11); step("idle_right", 1'b0, 2'b11, 2'b00, 3'd0);

        // Tick period: RUN at cycle 1, ticks at 5, 9, 13
        start_pause_in = 1'b1;
        step("period_c1", 1'b0, 2'b11, 2'b01, 3'd0);
        for (int c = 2; c <= 13; c++)
            step($sformatf("period_c%0d", c), (c == 5 || c == 9 || c == 13), 2'b11, 2'b01, 3'd0);

        // Reversal / duplicate filter
        dir_pulse(2'b10); step("filt_rev",  1'b0, 2'b11, 2'b01, 3'd0);
        dir_pulse(2'b00); step("filt_push", 1'b0, 2'b11, 2'b01, 3'd1);
        dir_pulse(2'b01); step("filt_opp",  1'b0, 2'b11, 2'b01, 3'd1);
        dir_pulse(2'b00); step("filt_dup_tick", 1'b1, 2'b00, 2'b01, 3'd0);

        // Full queue, restart to cur_dir 11 first
        reset_event_in = 1'b1; step("restart1", 1'b0, 2'b11, 2'b00, 3'd0);
        start_pause_in = 1'b1; step("start2",   1'b0, 2'b11, 2'b01, 3'd0);
        dir_pulse(2'b00); step("full_p1",   1'b0, 2'b11, 2'b01, 3'd1);
        dir_pulse(2'b10); step("full_p2",   1'b0, 2'b11, 2'b01, 3'd2);
        dir_pulse(2'b01); step("full_drop", 1'b0, 2'b11, 2'b01, 3'd2);
        dir_pulse(2'b01); step("full_wrap_push", 1'b1, 2'b00, 2'b01, 3'd2);
        for (int i = 0; i < 3; i++)
            step($sformatf("full_w1_%0d", i), 1'b0, 2'b00, 2'b01, 3'd2);
        step("full_tick2", 1'b1, 2'b10, 2'b01, 3'd1);
        for (int i = 0; i < 3; i++)
            step($sformatf("full_w2_%0d", i), 1'b0, 2'b10, 2'b01, 3'd1);
        step("full_tick3", 1'b1, 2'b01, 2'b01, 3'd0);

        // Pause with held counter 2
        step("pre_pause", 1'b0, 2'b01, 2'b01, 3'd0);
        start_pause_in = 1'b1; step("pause", 1'b0, 2'b01, 2'b10, 3'd0);
        for (int i = 0; i < 10; i++) begin
            dir_pulse(2'b00);
            step($sformatf("hold%0d", i), 1'b0, 2'b01, 2'b10, 3'd0);
        end
        start_pause_in = 1'b1; step("resume", 1'b0, 2'b01, 2'b01, 3'd0);
        step("resume_c1", 1'b0, 2'b01, 2'b01, 3'd0);
        step("resume_tick", 1'b1, 2'b01, 2'b01, 3'd0);

        // Priority: game_over beats start_pause at wrap; pop suppressed
        dir_pulse(2'b10); step("prio_push", 1'b0, 2'b01, 2'b01, 3'd1);
        step("prio_c2", 1'b0, 2'b01, 2'b01, 3'd1);
        step("prio_c3", 1'b0, 2'b01, 2'b01, 3'd1);
        game_over_in   = 1'b1;
        start_pause_in = 1'b1;
        step("prio_over", 1'b0, 2'b01, 2'b11, 3'd1);
        game_over_in = 1'b0;
        dir_pulse(2'b00); step("over_dir_ign", 1'b0, 2'b01, 2'b11, 3'd1);
        reset_event_in = 1'b1; step("prio_restart", 1'b0, 2'b11, 2'b00, 3'd0);

        // OVER + start_pause clears back to IDLE
        start_pause_in = 1'b1; step("start3", 1'b0, 2'b11, 2'b01, 3'd0);
        dir_pulse(2'b00); step("run_push", 1'b0, 2'b11, 2'b01, 3'd1);
        game_over_in = 1'b1; step("over2", 1'b0, 2'b11, 2'b11, 3'd1);
        game_over_in = 1'b0;
        start_pause_in = 1'b1; step("over_start", 1'b0, 2'b11, 2'b00, 3'd0);
        step("idle_hold", 1'b0, 2'b11, 2'b00, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
